// File: rtl/modn_updown_count.sv
// Parametrised modulo-N up/down counter with synchronous clamped load,
// wrap or saturate at the bounds, combinational terminal count and sticky overflow.
module modn_updown_count #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("modn_updown_count: MODULUS must be in 2..2**WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable in compares.
    localparam logic [WIDTH:0] MODV = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0] MAXV = MODV - 1'b1;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   q_inc;
    logic [WIDTH:0]   in_ext;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;

    assign q_ext  = {1'b0, q};
    assign q_inc  = q_ext + 1'b1;
    assign in_ext = {1'b0, in};
    assign at_top = (q_inc == MODV);
    assign at_bot = (q == '0);
    assign tc     = en & (up ? at_top : at_bot);

    always_comb begin
        q_nxt   = q;
        ovf_nxt = ovf;
        if (load) begin
            q_nxt   = (in_ext < MODV) ? in : MAXV[WIDTH-1:0];
            ovf_nxt = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    ovf_nxt = 1'b1;
                    q_nxt   = SATURATE ? q : '0;
                end else begin
                    q_nxt = q_inc[WIDTH-1:0];
                end
            end else begin
                if (at_bot) begin
                    ovf_nxt = 1'b1;
                    q_nxt   = SATURATE ? q : MAXV[WIDTH-1:0];
                end else begin
                    q_nxt = q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_modn_updown_count.sv
// Directed bench for modn_updown_count: wrap, saturate, clamp, cascade and full-scale instances.
module tb_modn_updown_count;

    logic clk, rst;
    int   vectors, miscompares;

    // mod-12 wrapping instance
    logic       load, en, up, tc, ovf;
    logic [3:0] in, q;
    // mod-12 saturating instance
    logic       s_load, s_en, s_up, s_tc, s_ovf;
    logic [3:0] s_in, s_q;
    // two-stage mod-10 cascade
    logic       c_en, c_tc0, c_tc1, c_ovf0, c_ovf1;
    logic [3:0] c_q0, c_q1;
    // full-scale mod-16
    logic       f_load, f_en, f_up, f_tc, f_ovf;
    logic [3:0] f_in, f_q;

    modn_updown_count #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .in(in), .en(en), .up(up),
        .q(q), .tc(tc), .ovf(ovf));

    modn_updown_count #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .load(s_load), .in(s_in), .en(s_en), .up(s_up),
        .q(s_q), .tc(s_tc), .ovf(s_ovf));

    modn_updown_count #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .rst(rst), .load(1'b0), .in(4'd0), .en(c_en), .up(1'b1),
        .q(c_q0), .tc(c_tc0), .ovf(c_ovf0));

    modn_updown_count #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .load(1'b0), .in(4'd0), .en(c_tc0), .up(1'b1),
        .q(c_q1), .tc(c_tc1), .ovf(c_ovf1));

    modn_updown_count #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
        .clk(clk), .rst(rst), .load(f_load), .in(f_in), .en(f_en), .up(f_up),
        .q(f_q), .tc(f_tc), .ovf(f_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int m0, m1;
    int up_q[4]   = '{10, 11, 0, 1};
    int up_ovf[4] = '{0, 0, 1, 1};
    int up_tc[4]  = '{0, 1, 0, 0};
    int dn_q[3]   = '{0, 11, 10};
    int dn_ovf[3] = '{0, 1, 1};
    int dn_tc[3]  = '{1, 0, 0};

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        load = 0; in = 0; en = 0; up = 1;
        s_load = 0; s_in = 0; s_en = 0; s_up = 1;
        c_en = 0;
        f_load = 0; f_in = 0; f_en = 0; f_up = 1;

        // reset state, tc gated by en/up during reset
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_tc_idle", int'(tc), 0);
        en = 1; up = 0; #1;
        chk("rst_tc_down", int'(tc), 1);
        en = 0; up = 1;
        neg(); rst = 0;
        cyc(); chk("post_rst_q", int'(q), 0);

        // async reset mid-cycle clears a loaded value before any edge
        neg(); load = 1; in = 5;
        cyc(); chk("load5", int'(q), 5);
        neg(); load = 0; #2 rst = 1; #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_ovf", int'(ovf), 0);
        neg(); rst = 0;

        for (int i = 0; i < 5; i++) begin
            cyc(); chk("hold_q", int'(q), 0);
        end

        // up-count wrap
        neg(); load = 1; in = 9;
        cyc(); chk("load9", int'(q), 9);
        neg(); load = 0; en = 1; up = 1; #1;
        chk("tc_at9", int'(tc), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("up_q", int'(q), up_q[i]);
            chk("up_ovf", int'(ovf), up_ovf[i]);
            chk("up_tc", int'(tc), up_tc[i]);
        end

        // down-count wrap; load clears ovf
        neg(); load = 1; in = 1; en = 0;
        cyc(); chk("load1_q", int'(q), 1); chk("load_clr_ovf", int'(ovf), 0);
        neg(); load = 0; en = 1; up = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("dn_q", int'(q), dn_q[i]);
            chk("dn_ovf", int'(ovf), dn_ovf[i]);
            chk("dn_tc", int'(tc), dn_tc[i]);
        end

        // clamp and priority
        neg(); load = 1; in = 14; en = 1; up = 1;
        cyc(); chk("clamp14_q", int'(q), 11); chk("clamp_ovf", int'(ovf), 0);
        neg(); in = 12;
        cyc(); chk("clamp12_q", int'(q), 11);
        neg(); in = 3;
        cyc(); chk("load_over_en", int'(q), 3);
        neg(); load = 0; en = 0;
        cyc(); chk("hold3", int'(q), 3);
        neg(); en = 1; up = 1;
        cyc(); chk("resume_up", int'(q), 4);
        neg(); up = 0;
        cyc(); chk("dir_change", int'(q), 3);
        neg(); en = 0;

        // saturating instance
        neg(); s_load = 1; s_in = 10;
        cyc(); chk("sat_load", int'(s_q), 10);
        neg(); s_load = 0; s_en = 1; s_up = 1;
        cyc(); chk("sat_q0", int'(s_q), 11); chk("sat_ovf0", int'(s_ovf), 0);
        chk("sat_tc", int'(s_tc), 1);
        cyc(); chk("sat_q1", int'(s_q), 11); chk("sat_ovf1", int'(s_ovf), 1);
        cyc(); chk("sat_q2", int'(s_q), 11); chk("sat_ovf2", int'(s_ovf), 1);
        neg(); s_up = 0;
        cyc(); chk("sat_dn0", int'(s_q), 10);
        cyc(); chk("sat_dn1", int'(s_q), 9); chk("sat_ovf_sticky", int'(s_ovf), 1);
        neg(); s_load = 1; s_in = 0;
        cyc(); chk("sat_load0", int'(s_q), 0); chk("sat_ovf_clr", int'(s_ovf), 0);
        neg(); s_load = 0;
        cyc(); chk("sat_bot_q", int'(s_q), 0); chk("sat_bot_ovf", int'(s_ovf), 1);
        neg(); s_en = 0;

        // cascade 0..25 with a reference two-digit model
        m0 = 0; m1 = 0;
        neg(); c_en = 1;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (m0 == 9) begin m0 = 0; m1 = m1 + 1; end
            else m0 = m0 + 1;
            chk("casc_q0", int'(c_q0), m0);
            chk("casc_q1", int'(c_q1), m1);
        end
        neg(); c_en = 0;
        chk("casc_final", int'({c_q1, c_q0}), int'({4'd2, 4'd5}));

        // full-scale modulus
        neg(); f_load = 1; f_in = 14;
        cyc(); chk("full_load", int'(f_q), 14);
        neg(); f_load = 0; f_en = 1; f_up = 1;
        cyc(); chk("full_15", int'(f_q), 15); chk("full_tc", int'(f_tc), 1);
        cyc(); chk("full_wrap", int'(f_q), 0); chk("full_ovf", int'(f_ovf), 1);
        neg(); f_up = 0;
        cyc(); chk("full_dn_wrap", int'(f_q), 15);
        neg(); f_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
